// File: rtl/decode_stage_if.sv
// Handshake and data bundle for decode_stage: raw instruction in, decoded bundle out.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_type;
    logic [RA_W-1:0] out_rs1;
    logic [RA_W-1:0] out_rs2;
    logic [RA_W-1:0] out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic            out_is_mul;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_pc, out_illegal, out_is_mul
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_type, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_imm, out_pc, out_illegal, out_is_mul
    );
endinterface

// File: rtl/decode_stage.sv
// RISC-V decode stage with optional two-entry skid buffer.
// Define DECODE_STAGE_MEXT_EN to decode M-extension (funct7=0000001) R-type operations.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int SKID = 1
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    decode_stage_if.slave bus
);

`ifdef DECODE_STAGE_MEXT_EN
    localparam logic MEXT_EN = 1'b1;
`else
    localparam logic MEXT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_S   = 3'd2,
        T_SB  = 3'd3,
        T_UJ  = 3'd4,
        T_U   = 3'd5,
        T_ILL = 3'd7
    } itype_e;

    typedef struct packed {
        itype_e          typ;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
        logic            is_mul;
    } bundle_t;

    localparam bundle_t RESET_BUNDLE = '{typ: T_ILL, rs1: '0, rs2: '0, rd: '0, funct3: '0,
                                         funct7: '0, imm: '0, pc: '0, illegal: 1'b0,
                                         is_mul: 1'b0};

    logic [31:0]        instr;
    logic [6:0]         funct7;
    logic signed [31:0] imm_raw;
    logic               use_rs1;
    logic               use_rs2;
    logic               use_rd;
    logic               bad_reg;
    bundle_t            dec;

    assign instr  = bus.in_instr;
    assign funct7 = instr[31:25];

    always_comb begin
        imm_raw    = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        dec        = RESET_BUNDLE;
        dec.funct3 = instr[14:12];
        dec.funct7 = funct7;
        dec.pc     = bus.in_pc;
        // Every legal opcode ends in 2'b11, so a bad instr[1:0] lands in default.
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.typ = T_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm_raw = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec.typ = T_R;
                end else if (MEXT_EN && funct7 == 7'b0000001) begin
                    dec.typ    = T_R;
                    dec.is_mul = 1'b1;
                end
            end
            7'b0100011: begin
                dec.typ = T_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec.typ = T_SB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.typ = T_UJ;
                use_rd  = 1'b1;
                imm_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.typ = T_U;
                use_rd  = 1'b1;
                imm_raw = {instr[31:12], 12'b0};
            end
            default: ;
        endcase
        // RV32E: any referenced register index of 16 or more is illegal.
        bad_reg = (RA_W < 5) && ((use_rs1 && instr[19]) || (use_rs2 && instr[24]) ||
                                 (use_rd && instr[11]));
        if (dec.typ == T_ILL || bad_reg) begin
            dec.typ     = T_ILL;
            dec.illegal = 1'b1;
            dec.is_mul  = 1'b0;
        end else begin
            dec.imm = XLEN'(imm_raw);
            if (use_rs1) dec.rs1 = instr[15 +: RA_W];
            if (use_rs2) dec.rs2 = instr[20 +: RA_W];
            if (use_rd)  dec.rd  = instr[7 +: RA_W];
        end
    end

    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    in_ready;
    logic    in_fire;
    logic    out_free;

    assign in_ready = (SKID != 0) ? in_ready_q : (!rst && (!out_valid_q || bus.out_ready));

    always_comb begin
        in_fire      = bus.in_valid && in_ready && !flush;
        out_free     = !out_valid_q || bus.out_ready;
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever the skid entry is full, so no accept collides here.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_d = dec;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= RESET_BUNDLE;
            skid_q       <= RESET_BUNDLE;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_type    = out_q.typ;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_funct3  = out_q.funct3;
    assign bus.out_funct7  = out_q.funct7;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_is_mul  = out_q.is_mul;

endmodule
